rps_guide_parser: RTL and testbench
===================================

Name: rps_guide_parser

Overview:
- Front end that feeds the rock-paper-scissors scoring block.
- Accepts the strategy guide as an ASCII byte stream over a valid/ready handshake and parses lines of the form "A X\n".
- Drives decoded 2-bit moves and a one-cycle play strobe into the scorer, with setup and hold timing that suits a posedge-play consumer.
- Counts the rounds it has issued and flags malformed input.

Parameters:
- CNT_W, 16, width of round_count; the counter saturates at all-ones.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- byte_in  input  8  guide byte (ASCII).
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  parser accepts byte_in this cycle; a transfer happens when byte_valid & byte_ready.
- player1_move  output  2  decoded opponent move; 01 = rock, 10 = paper, 11 = scissors.
- player2_raw  output  2  decoded second column; 01 = X, 10 = Y, 11 = Z.
- play  output  1  one-cycle round strobe.
- round_count  output  CNT_W  number of rounds issued.
- parse_error  output  1  sticky malformed-input flag.
- done  output  1  sticky end-of-stream flag.

Behaviour:
- Reset state:
  - State machine in S_P1.
  - player1_move = 00, player2_raw = 00.
  - play = 0, round_count = 0, parse_error = 0, done = 0.
  - byte_ready = 1 from the first cycle after reset.
- All outputs are registered. Reset asserted in any state, including mid-line or mid-issue, returns every output to its reset value on that edge. Any partially parsed line is discarded.
- States and transitions. Each transition below is taken only on an accepted byte, except the two timed states S_SETUP and S_PLAY.
  - S_P1:
    - 'A' / 'B' / 'C': latch 01 / 10 / 11 into an internal p1 register, go to S_SP.
    - 0x0A (blank line): ignored, stay in S_P1.
    - 0x04: go to S_DONE.
    - Any other byte: go to S_ERR.
  - S_SP:
    - 0x20: go to S_P2.
    - Any other byte: go to S_ERR.
  - S_P2:
    - 'X' / 'Y' / 'Z': latch 01 / 10 / 11 into an internal p2 register, go to S_EOL.
    - Any other byte: go to S_ERR.
  - S_EOL:
    - 0x0A: go to S_SETUP.
    - 0x04: go to S_SETUP and set an internal last flag.
    - Any other byte: go to S_ERR. The optional feature below adds a case here.
  - S_SETUP (one cycle):
    - The moves registered on the edge entering S_SETUP are player1_move = p1 and player2_raw = p2.
    - byte_ready = 0.
    - Go to S_PLAY.
  - S_PLAY (one cycle):
    - play = 1 and byte_ready = 0.
    - On the exit edge, round_count increments; it holds at all-ones once saturated.
    - Exit to S_DONE if last is set, else to S_P1.
  - S_ERR:
    - parse_error = 1, sticky until rst.
    - byte_ready = 1 and all bytes are drained and discarded.
    - No further play strobes are issued.
  - S_DONE:
    - done = 1, sticky until rst.
    - byte_ready = 0.
- Timing, taking the terminating byte as accepted in cycle N:
  - Moves are visible from cycle N+1.
  - play is high in cycle N+2 only.
  - Moves stay stable until the next line's S_SETUP. They therefore give one cycle of setup before the play rising edge and hold well after it.
  - The incremented round_count is visible in cycle N+3.
  - Peak throughput is one round per 6 cycles (4 bytes plus 2 issue cycles).
- byte_in is ignored whenever byte_valid = 0. No state advances without a transfer.
- Lowercase letters are errors. Case-sensitive matching is required.
- A 0x04 received in S_P1 ends the stream without issuing a round.

Optional Feature:
- Macro: RPS_PARSER_CRLF_EN.
- Defined:
  - In S_EOL, 0x0D is accepted and moves to an extra state S_CR.
  - S_CR accepts only 0x0A, going to S_SETUP. Any other byte in S_CR goes to S_ERR.
  - In S_P1, 0x0D is ignored.
- Undefined: 0x0D is treated as any other unexpected byte, i.e. it causes S_ERR in every state.

Test Plan:
- Stream "A Y\nB X\nC Z\n" with byte_valid held high:
  - play is pulsed 3 times, with moves (01,10), (10,01), (11,11).
  - Each play occurs 2 cycles after its LF is accepted.
  - round_count ends at 3.
  - byte_ready is low for exactly the 2 issue cycles of each round.
- "A Y" then 0x04 with no LF:
  - One play with (01,10), then done = 1.
  - byte_ready = 0 afterwards.
  - round_count = 1.
- "A Q\n" then "B X\n":
  - parse_error = 1 after 'Q'.
  - No play pulse ever occurs.
  - byte_ready stays 1 and the later bytes are discarded.
  - round_count = 0.
- Randomly deasserted byte_valid during "C X\n\n\nA Z\n":
  - Same moves and play count (2) as the unthrottled stream.
  - Blank lines are ignored.
- Assert rst in the cycle play = 1:
  - The next cycle shows play = 0, round_count = 0 and moves = 00.
  - A subsequent "B Z\n" parses normally.
- With RPS_PARSER_CRLF_EN, "A X\r\n": one play with (01,01). Without the macro, the same stream sets parse_error = 1 with no play.

Source files
------------

// File: rtl/rps_guide_parser.sv
// rtl/rps_guide_parser.sv - ASCII strategy-guide parser driving moves and a play strobe into the RPS scorer
// Optional CR-LF line endings are enabled with RPS_PARSER_CRLF_EN.
module rps_guide_parser #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [1:0]       player1_move,
    output logic [1:0]       player2_raw,
    output logic             play,
    output logic [CNT_W-1:0] round_count,
    output logic             parse_error,
    output logic             done
);
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_EOT = 8'h04;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_A   = 8'h41;
    localparam logic [7:0] CH_B   = 8'h42;
    localparam logic [7:0] CH_C   = 8'h43;
    localparam logic [7:0] CH_X   = 8'h58;
    localparam logic [7:0] CH_Y   = 8'h59;
    localparam logic [7:0] CH_Z   = 8'h5A;
`ifdef RPS_PARSER_CRLF_EN
    localparam logic [7:0] CH_CR  = 8'h0D;
`endif

    typedef enum logic [3:0] {
        S_P1, S_SP, S_P2, S_EOL, S_SETUP, S_PLAY, S_ERR, S_DONE, S_CR
    } state_t;

    state_t     state;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       last;
    logic       accept;

    assign accept = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_P1;
            p1           <= 2'b00;
            p2           <= 2'b00;
            last         <= 1'b0;
            player1_move <= 2'b00;
            player2_raw  <= 2'b00;
            play         <= 1'b0;
            round_count  <= '0;
            parse_error  <= 1'b0;
            done         <= 1'b0;
            byte_ready   <= 1'b1;
        end else begin
            play <= 1'b0;
            case (state)
                S_P1: if (accept) begin
                    case (byte_in)
                        CH_A: begin p1 <= 2'b01; state <= S_SP; end
                        CH_B: begin p1 <= 2'b10; state <= S_SP; end
                        CH_C: begin p1 <= 2'b11; state <= S_SP; end
                        CH_LF: state <= S_P1;
`ifdef RPS_PARSER_CRLF_EN
                        CH_CR: state <= S_P1;
`endif
                        CH_EOT: begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            byte_ready <= 1'b0;
                        end
                        default: begin state <= S_ERR; parse_error <= 1'b1; end
                    endcase
                end
                S_SP: if (accept) begin
                    if (byte_in == CH_SP) begin
                        state <= S_P2;
                    end else begin
                        state       <= S_ERR;
                        parse_error <= 1'b1;
                    end
                end
                S_P2: if (accept) begin
                    case (byte_in)
                        CH_X: begin p2 <= 2'b01; state <= S_EOL; end
                        CH_Y: begin p2 <= 2'b10; state <= S_EOL; end
                        CH_Z: begin p2 <= 2'b11; state <= S_EOL; end
                        default: begin state <= S_ERR; parse_error <= 1'b1; end
                    endcase
                end
                // Moves are published here so they lead the play strobe by one cycle.
                S_EOL: if (accept) begin
                    case (byte_in)
                        CH_LF, CH_EOT: begin
                            state        <= S_SETUP;
                            player1_move <= p1;
                            player2_raw  <= p2;
                            byte_ready   <= 1'b0;
                            last         <= (byte_in == CH_EOT);
                        end
`ifdef RPS_PARSER_CRLF_EN
                        CH_CR: state <= S_CR;
`endif
                        default: begin state <= S_ERR; parse_error <= 1'b1; end
                    endcase
                end
`ifdef RPS_PARSER_CRLF_EN
                S_CR: if (accept) begin
                    if (byte_in == CH_LF) begin
                        state        <= S_SETUP;
                        player1_move <= p1;
                        player2_raw  <= p2;
                        byte_ready   <= 1'b0;
                        last         <= 1'b0;
                    end else begin
                        state       <= S_ERR;
                        parse_error <= 1'b1;
                    end
                end
`endif
                S_SETUP: begin
                    state <= S_PLAY;
                    play  <= 1'b1;
                end
                S_PLAY: begin
                    if (round_count != '1)
                        round_count <= round_count + CNT_W'(1);
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= S_P1;
                        byte_ready <= 1'b1;
                    end
                end
                S_ERR, S_DONE: begin
                end
                default: begin
                    state       <= S_ERR;
                    parse_error <= 1'b1;
                    byte_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rps_guide_parser.sv
// tb/tb_rps_guide_parser.sv - self-checking bench for rps_guide_parser against a line-pattern reference model
module tb_rps_guide_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [1:0]  player1_move;
    logic [1:0]  player2_raw;
    logic        play;
    logic [15:0] round_count;
    logic        parse_error;
    logic        done;

    rps_guide_parser #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .player1_move(player1_move), .player2_raw(player2_raw),
        .play(play), .round_count(round_count), .parse_error(parse_error), .done(done)
    );

    always #5 clk = ~clk;

`ifdef RPS_PARSER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    int ncmp = 0;
    int nfail = 0;

    int         cyc;
    int         rdy_low;
    int         acc_cyc[$];
    int         play_cyc[$];
    logic [3:0] play_mv[$];
    logic [3:0] mv_hist[$];

    logic [7:0] stim[$];
    int         exp_p1[$];
    int         exp_p2[$];
    int         exp_term[$];
    bit         exp_err;
    bit         exp_done;
    int         exp_nacc;

    always @(negedge clk) begin
        mv_hist.push_back({player1_move, player2_raw});
        if (byte_valid && byte_ready) acc_cyc.push_back(cyc);
        if (play) begin
            play_cyc.push_back(cyc);
            play_mv.push_back({player1_move, player2_raw});
        end
        if (!byte_ready && !done) rdy_low++;
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void load(input string str);
        stim = {};
        for (int i = 0; i < str.len(); i++) stim.push_back(str[i]);
    endfunction

    // A guide is a sequence of optional blank lines and "<A-C> <X-Z><LF|EOT>" lines.
    function automatic void model(input logic [7:0] s[$]);
        int i;
        int n;
        int term;
        logic [7:0] t;
        exp_p1 = {}; exp_p2 = {}; exp_term = {};
        exp_err = 0; exp_done = 0;
        n = s.size();
        exp_nacc = n;
        i = 0;
        while (i < n) begin
            if (s[i] == 8'h0A || (CRLF && s[i] == 8'h0D)) begin i++; continue; end
            if (s[i] == 8'h04) begin exp_done = 1; exp_nacc = i + 1; return; end
            if (!(s[i] inside {8'h41, 8'h42, 8'h43})) begin exp_err = 1; return; end
            if (i + 1 >= n) return;
            if (s[i+1] != 8'h20) begin exp_err = 1; return; end
            if (i + 2 >= n) return;
            if (!(s[i+2] inside {8'h58, 8'h59, 8'h5A})) begin exp_err = 1; return; end
            if (i + 3 >= n) return;
            t = s[i+3];
            if (t == 8'h0A || t == 8'h04) term = i + 3;
            else if (CRLF && t == 8'h0D) begin
                if (i + 4 >= n) return;
                if (s[i+4] != 8'h0A) begin exp_err = 1; return; end
                term = i + 4;
            end else begin exp_err = 1; return; end
            exp_p1.push_back(int'(s[i]) - 8'h41 + 1);
            exp_p2.push_back(int'(s[i+2]) - 8'h58 + 1);
            exp_term.push_back(term);
            if (t == 8'h04) begin exp_done = 1; exp_nacc = term + 1; return; end
            i = term + 1;
        end
    endfunction

    task automatic clear_mon();
        cyc = 0; rdy_low = 0;
        acc_cyc = {}; play_cyc = {}; play_mv = {}; mv_hist = {};
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_byte(input logic [7:0] b, input int thr, output bit ok);
        int t;
        t = 0;
        ok = 0;
        byte_in = b;
        while (!ok && t < 40) begin
            byte_valid = ($urandom_range(0, 99) >= thr);
            @(negedge clk);
            ok = byte_valid && byte_ready;
            @(posedge clk); #1;
            t++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_stream(input string name, input int thr, input bit rst_first);
        bit ok;
        int np;
        if (rst_first) do_reset();
        model(stim);
        foreach (stim[i]) begin
            send_byte(stim[i], thr, ok);
            if (!ok) break;
        end
        repeat (12) @(posedge clk);
        #1;
        np = exp_p1.size();
        chk({name, ".accepted"}, acc_cyc.size(), exp_nacc);
        chk({name, ".plays"}, play_cyc.size(), np);
        for (int k = 0; k < np && k < play_cyc.size(); k++) begin
            chk({name, ".moves"}, play_mv[k], {exp_p1[k][1:0], exp_p2[k][1:0]});
            if (exp_term[k] < acc_cyc.size()) begin
                chk({name, ".play_lat"}, play_cyc[k], acc_cyc[exp_term[k]] + 2);
                chk({name, ".move_setup"}, mv_hist[acc_cyc[exp_term[k]] + 1],
                    {exp_p1[k][1:0], exp_p2[k][1:0]});
            end
        end
        chk({name, ".round_count"}, round_count, np);
        chk({name, ".parse_error"}, parse_error, exp_err);
        chk({name, ".done"}, done, exp_done);
        chk({name, ".ready_low"}, rdy_low, 2 * np);
        chk({name, ".byte_ready"}, byte_ready, !exp_done);
    endtask

    initial begin
        bit ok;
        bit seen;
        int nl;
        int idx;

        do_reset();
        @(negedge clk);
        chk("reset.play", play, 1'b0);
        chk("reset.round_count", round_count, 0);
        chk("reset.parse_error", parse_error, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.moves", {player1_move, player2_raw}, 4'h0);
        chk("reset.byte_ready", byte_ready, 1'b1);

        load("A Y\nB X\nC Z\n");
        run_stream("three", 0, 1'b1);
        load("A Y\004");
        run_stream("eot_no_lf", 0, 1'b1);
        load("A Q\nB X\n");
        run_stream("bad_p2", 0, 1'b1);
        load("C X\n\n\nA Z\n");
        run_stream("throttled", 40, 1'b1);
        load("\004A X\n");
        run_stream("eot_at_start", 0, 1'b1);
        load("a X\n");
        run_stream("lowercase", 0, 1'b1);
        load("A X\015\n");
        run_stream("crlf", 0, 1'b1);
        load("A X\n\015\nB Y\n");
        run_stream("cr_blank", 20, 1'b1);

        // Reset landing exactly on the play cycle must wipe the round.
        do_reset();
        load("A X\n");
        foreach (stim[i]) send_byte(stim[i], 0, ok);
        seen = 0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            seen = play;
        end
        chk("rst_in_play.seen", seen, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_play.play", play, 1'b0);
        chk("rst_in_play.round_count", round_count, 0);
        chk("rst_in_play.moves", {player1_move, player2_raw}, 4'h0);
        chk("rst_in_play.byte_ready", byte_ready, 1'b1);
        clear_mon();
        load("B Z\n");
        run_stream("after_rst", 0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            stim = {};
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 3) == 0) stim.push_back(8'h0A);
                stim.push_back(8'(8'h41 + $urandom_range(0, 2)));
                stim.push_back(8'h20);
                stim.push_back(8'(8'h58 + $urandom_range(0, 2)));
                stim.push_back((l == nl - 1 && $urandom_range(0, 2) == 0) ? 8'h04 : 8'h0A);
            end
            if ($urandom_range(0, 3) == 0) stim.push_back(8'h04);
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, stim.size() - 1);
                stim[idx] = 8'(8'h00 + $urandom_range(0, 8'h7A));
            end
            stim.push_back(8'h42);
            run_stream("random", $urandom_range(0, 50), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
